// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolution unit: comparator result codes,
// conditional-branch funct3 encodings and the signed-compare operand helper.
`ifndef BRANCH_RESOLVE_UNIT_PKG_SV
`define BRANCH_RESOLVE_UNIT_PKG_SV

package branch_resolve_unit_pkg;

  // Comparator result codes; 2'b00 is never produced by a healthy comparator
  localparam logic [1:0] OP1_GT_OP2 = 2'b01;
  localparam logic [1:0] OP1_LT_OP2 = 2'b10;
  localparam logic [1:0] OP1_EQ_OP2 = 2'b11;

  // Conditional branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Flipping the sign bit maps two's-complement order onto unsigned order
  function automatic logic [63:0] msb_flip(input logic [63:0] v);
    return {~v[63], v[62:0]};
  endfunction

endpackage

`endif

// File: rtl/branch_resolve_unit_cmp64u.sv
// Shared 64-bit unsigned magnitude comparator producing a 2-bit compare code.
module Cmp64U
  import branch_resolve_unit_pkg::*;
(
  input  logic [63:0] i_op1,
  input  logic [63:0] i_op2,
  output logic [1:0]  o_code
);

  // Unsigned three-way compare
  always_comb begin
    o_code = OP1_EQ_OP2;
    if (i_op1 > i_op2) begin
      o_code = OP1_GT_OP2;
    end else if (i_op1 < i_op2) begin
      o_code = OP1_LT_OP2;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage pipelined conditional branch resolution unit.
// S1 registers the request; compare and condition evaluation run on the S1
// registers; S2 registers the result and drives the out_* ports.
// Optional feature: define BRU_PERF_CNT_EN to add the perf_branches and
// perf_mispredicts counter ports.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic            out_misalign
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  // S1 request registers
  logic            r_s1_valid;
  logic [2:0]      r_s1_funct3;
  logic [XLEN-1:0] r_s1_rs1;
  logic [XLEN-1:0] r_s1_rs2;
  logic [XLEN-1:0] r_s1_pc;
  logic [XLEN-1:0] r_s1_imm;
  logic            r_s1_pred;

  // S2 result registers
  logic            r_s2_valid;
  logic            r_s2_taken;
  logic [XLEN-1:0] r_s2_redirect;
  logic            r_s2_mispredict;
  logic            r_s2_illegal;
  logic            r_s2_misalign;

  // Combinational resolve path
  logic            w_signed;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [1:0]      w_code;
  logic            w_cond;
  logic            w_illegal;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_redirect;
  logic            w_mispredict;
  logic            w_misalign;

  // Handshake
  logic            w_s2_load;
  logic            w_s1_advance;
  logic            w_consume;

  // Signed compares flip the MSB so the unsigned comparator can be shared
  always_comb begin
    w_signed = (r_s1_funct3 == F3_BLT) || (r_s1_funct3 == F3_BGE);
    w_op1    = w_signed ? msb_flip(r_s1_rs1) : r_s1_rs1;
    w_op2    = w_signed ? msb_flip(r_s1_rs2) : r_s1_rs2;
  end

  Cmp64U u_cmp (
    .i_op1  (w_op1),
    .i_op2  (w_op2),
    .o_code (w_code)
  );

  // Branch condition, legality and target selection
  always_comb begin
    w_cond = 1'b0;
    case (r_s1_funct3)
      F3_BEQ:           w_cond = (w_code == OP1_EQ_OP2);
      F3_BNE:           w_cond = (w_code != OP1_EQ_OP2);
      F3_BLT, F3_BLTU:  w_cond = (w_code == OP1_LT_OP2);
      F3_BGE, F3_BGEU:  w_cond = (w_code != OP1_LT_OP2);
      default:          w_cond = 1'b0;
    endcase
    // A 00 code means a broken comparator; treat the entry as illegal
    w_illegal    = (r_s1_funct3 == 3'b010) || (r_s1_funct3 == 3'b011) ||
                   (w_code == 2'b00);
    w_taken      = w_cond & ~w_illegal;
    w_target     = r_s1_pc + r_s1_imm;
    w_pc4        = r_s1_pc + XLEN'(4);
    w_redirect   = w_taken ? w_target : w_pc4;
    w_mispredict = ~w_illegal & (w_taken != r_s1_pred);
    w_misalign   = w_taken & (w_target[1:0] != 2'b00);
  end

  // Stage advance and input backpressure; flush blocks any same-cycle input
  always_comb begin
    w_s2_load    = ~r_s2_valid | out_ready;
    w_s1_advance = r_s1_valid & w_s2_load;
    in_ready     = ~flush & (~r_s1_valid | w_s1_advance);
    w_consume    = r_s2_valid & out_ready & ~flush;
  end

  // S1 request register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_funct3 <= 3'b000;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_pc     <= '0;
      r_s1_imm    <= '0;
      r_s1_pred   <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_funct3 <= in_funct3;
        r_s1_rs1    <= in_rs1;
        r_s1_rs2    <= in_rs2;
        r_s1_pc     <= in_pc;
        r_s1_imm    <= in_imm;
        r_s1_pred   <= in_pred_taken;
      end
    end
  end

  // S2 result register; payload holds while a result is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid      <= 1'b0;
      r_s2_taken      <= 1'b0;
      r_s2_redirect   <= '0;
      r_s2_mispredict <= 1'b0;
      r_s2_illegal    <= 1'b0;
      r_s2_misalign   <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_taken      <= w_taken;
        r_s2_redirect   <= w_redirect;
        r_s2_mispredict <= w_mispredict;
        r_s2_illegal    <= w_illegal;
        r_s2_misalign   <= w_misalign;
      end
    end
  end

  assign out_valid       = r_s2_valid;
  assign out_taken       = r_s2_taken;
  assign out_redirect_pc = r_s2_redirect;
  assign out_mispredict  = r_s2_mispredict;
  assign out_illegal     = r_s2_illegal;
  assign out_misalign    = r_s2_misalign;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  // Count consumed results only; flushed entries never reach w_consume
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (w_consume) begin
      if (!r_s2_illegal) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end
      if (r_s2_mispredict) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`else
  logic w_unused_consume;
  assign w_unused_consume = w_consume;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [63:0] in_pc;
  logic [63:0] in_imm;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [63:0] out_redirect_pc;
  logic        out_mispredict;
  logic        out_illegal;
  logic        out_misalign;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_funct3       (in_funct3),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_pc           (in_pc),
    .in_imm          (in_imm),
    .in_pred_taken   (in_pred_taken),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_taken       (out_taken),
    .out_redirect_pc (out_redirect_pc),
    .out_mispredict  (out_mispredict),
    .out_illegal     (out_illegal),
    .out_misalign    (out_misalign)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  int n_checks = 0;
  int n_pass   = 0;

  logic        mon_en = 1'b0;
  logic [64:0] q[$];
  logic        seen;

  // Record consumed results in order while enabled
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) q.push_back({out_taken, out_redirect_pc});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_out(input string t, input logic e_taken, input logic [63:0] e_rpc,
                           input logic e_mis, input logic e_ill, input logic e_mal);
    check_eq({t, ".valid"},    64'(out_valid),      64'd1);
    check_eq({t, ".taken"},    64'(out_taken),      64'(e_taken));
    check_eq({t, ".redirect"}, out_redirect_pc,     e_rpc);
    check_eq({t, ".mispred"},  64'(out_mispredict), 64'(e_mis));
    check_eq({t, ".illegal"},  64'(out_illegal),    64'(e_ill));
    check_eq({t, ".misalign"}, 64'(out_misalign),   64'(e_mal));
  endtask

  task automatic check_empty(input string t);
    check_eq({t, ".valid"},    64'(out_valid),      64'd0);
    check_eq({t, ".in_ready"}, 64'(in_ready),       64'd1);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] imm, input logic pred);
    in_funct3     = f3;
    in_rs1        = a;
    in_rs2        = b;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
    in_valid      = 1'b1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] pc, input logic [63:0] imm, input logic pred);
    logic done;
    done = 1'b0;
    drive(f3, a, b, pc, imm, pred);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_one(input string t, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] pc, input logic [63:0] imm,
                         input logic pred, input logic e_taken, input logic [63:0] e_rpc,
                         input logic e_mis, input logic e_ill, input logic e_mal);
    @(posedge clk);
    #1;
    send(f3, a, b, pc, imm, pred);
    @(negedge clk);
    check_eq({t, ".latency"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check_out(t, e_taken, e_rpc, e_mis, e_ill, e_mal);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] exp_q[4];
    exp_q[0] = {1'b1, 64'h2010};
    exp_q[1] = {1'b0, 64'h2008};
    exp_q[2] = {1'b1, 64'h2018};
    exp_q[3] = {1'b1, 64'h201C};

    rst = 1'b1; in_valid = 1'b0; in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; in_pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_empty("reset");
    check_eq("reset.taken",    64'(out_taken),      64'd0);
    check_eq("reset.redirect", out_redirect_pc,     64'd0);
    check_eq("reset.mispred",  64'(out_mispredict), 64'd0);
    check_eq("reset.illegal",  64'(out_illegal),    64'd0);
    check_eq("reset.misalign", 64'(out_misalign),   64'd0);
`ifdef BRU_PERF_CNT_EN
    check_eq("reset.perf_br",  64'(perf_branches),    64'd0);
    check_eq("reset.perf_mis", 64'(perf_mispredicts), 64'd0);
`endif

    // Single transactions
    run_one("blt",      BLT,  NEG1, 64'd1, 64'h1000, 64'h20, 1'b0, 1'b1, 64'h1020, 1'b1, 1'b0, 1'b0);
    run_one("bltu",     BLTU, NEG1, 64'd1, 64'h1000, 64'h20, 1'b1, 1'b0, 64'h1004, 1'b1, 1'b0, 1'b0);
    run_one("ill010",   3'b010, 64'd0, 64'd0, 64'h3000, 64'h40, 1'b1, 1'b0, 64'h3004, 1'b0, 1'b1, 1'b0);
    run_one("ill011",   3'b011, 64'd5, 64'd5, 64'h3100, 64'h40, 1'b1, 1'b0, 64'h3104, 1'b0, 1'b1, 1'b0);
    run_one("wrap",     BEQ,  64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1, 1'b1, 64'h4,
            1'b0, 1'b0, 1'b0);
    run_one("misalign", BEQ,  64'd9, 64'd9, 64'h4000, 64'h6, 1'b1, 1'b1, 64'h4006, 1'b0, 1'b0, 1'b1);
    run_one("bge_s",    BGE,  64'd1, NEG1, 64'h5000, 64'h100, 1'b0, 1'b1, 64'h5100, 1'b1, 1'b0, 1'b0);
    run_one("bgeu",     BGEU, 64'd1, NEG1, 64'h5000, 64'h100, 1'b0, 1'b0, 64'h5004, 1'b0, 1'b0, 1'b0);
    run_one("bne_neg",  BNE,  64'd3, 64'd4, 64'h6000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1,
            64'h5FF0, 1'b0, 1'b0, 1'b0);

    // Backpressure: two entries fill the pipe, third is held off
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    q.delete();
    mon_en = 1'b1;
    send(BEQ, 64'd5, 64'd5, 64'h2000, 64'h10, 1'b1);
    send(BNE, 64'd5, 64'd5, 64'h2004, 64'h10, 1'b1);
    drive(BGE, 64'd5, 64'd5, 64'h2008, 64'h10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("bp.in_ready%0d", k), 64'(in_ready),  64'd0);
      check_eq($sformatf("bp.valid%0d", k),    64'(out_valid), 64'd1);
      check_eq($sformatf("bp.taken%0d", k),    64'(out_taken), 64'd1);
      check_eq($sformatf("bp.redir%0d", k),    out_redirect_pc, 64'h2010);
      if (k < 2) @(posedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(BGE,  64'd5, 64'd5, 64'h2008, 64'h10, 1'b1);
    send(BGEU, 64'd5, 64'd5, 64'h200C, 64'h10, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check_eq("bp.count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) begin
        check_eq($sformatf("bp.order_taken%0d", i), 64'(q[i][64]), 64'(exp_q[i][64]));
        check_eq($sformatf("bp.order_redir%0d", i), q[i][63:0], exp_q[i][63:0]);
      end
    end

    // Flush with both stages full and a same-cycle request
    out_ready = 1'b0;
    send(BEQ, 64'd1, 64'd1, 64'h7000, 64'h10, 1'b0);
    send(BNE, 64'd1, 64'd1, 64'h7004, 64'h10, 1'b0);
    drive(BLT, 64'd1, 64'd2, 64'h7008, 64'h10, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush.in_ready", 64'(in_ready),  64'd0);
    check_eq("flush.full",     64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_empty("flush.after");
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush.no_accept", 64'(seen), 64'd0);

    // Reset mid-stream
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(BLT, NEG1, 64'd1, 64'h8000, 64'h22, 1'b0);
    send(BEQ, 64'd1, 64'd1, 64'h8100, 64'h10, 1'b0);
    @(negedge clk);
    check_eq("rst_mid.full", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_empty("rst_mid");
    check_eq("rst_mid.taken",    64'(out_taken),    64'd0);
    check_eq("rst_mid.redirect", out_redirect_pc,   64'd0);
    check_eq("rst_mid.misalign", 64'(out_misalign), 64'd0);
`ifdef BRU_PERF_CNT_EN
    check_eq("rst_mid.perf_br",  64'(perf_branches),    64'd0);
    check_eq("rst_mid.perf_mis", 64'(perf_mispredicts), 64'd0);
`endif
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("rst_mid.no_output", 64'(seen), 64'd0);

`ifdef BRU_PERF_CNT_EN
    // Five legal (two mispredicted), one illegal, one flushed
    run_one("p_beq",  BEQ,  64'd1, 64'd1, 64'h9000, 64'h8, 1'b1, 1'b1, 64'h9008, 1'b0, 1'b0, 1'b0);
    run_one("p_bne",  BNE,  64'd1, 64'd1, 64'h9100, 64'h8, 1'b1, 1'b0, 64'h9104, 1'b1, 1'b0, 1'b0);
    run_one("p_bltu", BLTU, 64'd1, 64'd2, 64'h9200, 64'h8, 1'b1, 1'b1, 64'h9208, 1'b0, 1'b0, 1'b0);
    run_one("p_bgeu", BGEU, 64'd1, 64'd2, 64'h9300, 64'h8, 1'b1, 1'b0, 64'h9304, 1'b1, 1'b0, 1'b0);
    run_one("p_blt",  BLT,  64'd2, 64'd1, 64'h9400, 64'h8, 1'b0, 1'b0, 64'h9404, 1'b0, 1'b0, 1'b0);
    run_one("p_ill",  3'b011, 64'd0, 64'd0, 64'h9500, 64'h8, 1'b1, 1'b0, 64'h9504, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    send(BEQ, 64'd1, 64'd1, 64'h9600, 64'h8, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("perf.branches",    64'(perf_branches),    64'd5);
    check_eq("perf.mispredicts", 64'(perf_mispredicts), 64'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
